// File: rtl/dec_pkg.sv
// Shared definitions for the dec_n_pipe decoder: mode constants, state type
// and the one-hot width helper.
package dec_pkg;

  localparam int MODE_LEVEL = 0;
  localparam int MODE_PULSE = 1;

  typedef enum logic {IDLE, PULSE} dec_state_t;

  function automatic int onehot_width(input int in_w);
    return 2 ** in_w;
  endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational binary-to-one-hot map; one comparator per output line.
module dec_onehot
  import dec_pkg::*;
#(
  parameter  int IN_W  = 2,
  localparam int OUT_W = onehot_width(IN_W)
) (
  input  logic [IN_W-1:0]  sel,
  output logic [OUT_W-1:0] onehot
);

  for (genvar i = 0; i < OUT_W; i++) begin : g_line
    assign onehot[i] = (sel == IN_W'(i));
  end

endmodule

// File: rtl/dec_n_pipe.sv
// Registered N-to-2^N one-hot decoder with valid/ready intake and either
// level-hold or fixed-width pulse output.
module dec_n_pipe
  import dec_pkg::*;
#(
  parameter  int IN_W      = 2,
  parameter  int MODE      = 0,
  parameter  int PULSE_LEN = 1,
  localparam int OUT_W     = onehot_width(IN_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic             out_valid
);

  if (IN_W < 1 || IN_W > 6) begin : g_bad_in_w
    $error("dec_n_pipe: IN_W must be 1..6");
  end
  if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_pulse_len
    $error("dec_n_pipe: PULSE_LEN must be 1..255");
  end
  if (MODE != MODE_LEVEL && MODE != MODE_PULSE) begin : g_bad_mode
    $error("dec_n_pipe: MODE must be 0 or 1");
  end

  localparam logic [7:0] CNT_INIT = 8'(PULSE_LEN - 1);

  dec_state_t       state;
  logic [7:0]       cnt;
  logic [OUT_W-1:0] dec;
  logic             acc;

  // rst_n is folded in so ready drops with reset, not on the next edge
  assign in_ready = rst_n && en && !clr && (state == IDLE);
  assign acc      = in_valid && in_ready;

  dec_onehot #(.IN_W(IN_W)) u_dec (
    .sel    (in),
    .onehot (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
    end else if (clr) begin
      out       <= '0;
      out_valid <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
    end else begin
      out_valid <= acc;
      if (acc) begin
        out <= dec;
        if (MODE == MODE_PULSE) begin
          state <= PULSE;
          cnt   <= CNT_INIT;
        end
      end else if (state == PULSE) begin
        // counter reaching zero ends the pulse; en does not pause it
        if (cnt == 8'd0) begin
          out   <= '0;
          state <= IDLE;
        end else begin
          cnt <= cnt - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dec_n_pipe.sv
// Bench for dec_n_pipe: three instances (level, short pulse, long pulse) on
// shared stimulus, checked every cycle against a time-based reference model.
module tb_dec_n_pipe;

  localparam int PL_B = 3;
  localparam int PL_C = 5;

  logic       clk = 1'b0, rst_n = 1'b1, en = 1'b0, clr = 1'b0, vld = 1'b0;
  logic [2:0] din = '0;
  logic [7:0] out_a, out_c;
  logic [3:0] out_b;
  logic       ov_a, ov_b, ov_c, rdy_a, rdy_b, rdy_c;
  int         tests = 0, fails = 0;

  always #5 clk = ~clk;

  dec_n_pipe #(.IN_W(3), .MODE(0), .PULSE_LEN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(vld),
    .in_ready(rdy_a), .in(din), .out(out_a), .out_valid(ov_a));

  dec_n_pipe #(.IN_W(2), .MODE(1), .PULSE_LEN(PL_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(vld),
    .in_ready(rdy_b), .in(din[1:0]), .out(out_b), .out_valid(ov_b));

  dec_n_pipe #(.IN_W(3), .MODE(1), .PULSE_LEN(PL_C)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(vld),
    .in_ready(rdy_c), .in(din), .out(out_c), .out_valid(ov_c));

  // Reference model: n counts processed edges; a pulse accepted at edge a is
  // high for edges a..a+PL-1, and the unit is free again once n >= end.
  int         n = 0, b_end = 0, c_end = 0;
  logic [7:0] a_out = '0;
  logic [1:0] b_val = '0;
  logic [2:0] c_val = '0;
  logic       a_ov = 1'b0, b_ov = 1'b0, c_ov = 1'b0;
  logic       go;

  assign go = rst_n && en && !clr && vld;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= '0;
      a_ov  <= 1'b0;
      b_ov  <= 1'b0;
      c_ov  <= 1'b0;
      b_end <= n;
      c_end <= n;
    end else begin
      n    <= n + 1;
      a_ov <= go;
      b_ov <= go && (n >= b_end);
      c_ov <= go && (n >= c_end);
      if (clr) begin
        a_out <= '0;
        b_end <= n + 1;
        c_end <= n + 1;
      end else begin
        if (go) a_out <= 8'(1) << din;
        if (go && n >= b_end) begin
          b_val <= din[1:0];
          b_end <= n + 1 + PL_B;
        end
        if (go && n >= c_end) begin
          c_val <= din;
          c_end <= n + 1 + PL_C;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_out_a", out_a, a_out);
    chk("m_ov_a",  ov_a,  a_ov);
    chk("m_rdy_a", rdy_a, rst_n && en && !clr);
    chk("m_out_b", out_b, (n < b_end) ? 8'(4'(1) << b_val) : 8'h00);
    chk("m_ov_b",  ov_b,  b_ov);
    chk("m_rdy_b", rdy_b, rst_n && en && !clr && (n >= b_end));
    chk("m_out_c", out_c, (n < c_end) ? (8'(1) << c_val) : 8'h00);
    chk("m_ov_c",  ov_c,  c_ov);
    chk("m_rdy_c", rdy_c, rst_n && en && !clr && (n >= c_end));
  end

  // Inputs change at posedge+2; results of that edge are sampled right after.
  task automatic cyc(input logic v, input logic [2:0] d, input logic e, input logic c);
    vld = v; din = d; en = e; clr = c;
    @(posedge clk);
    #2;
  endtask

  logic [7:0] seq_a  [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] seq_b  [6] = '{8'h4, 8'h4, 8'h4, 8'h0, 8'h4, 8'h4};
  logic [7:0] seq_bv [6] = '{8'h1, 8'h0, 8'h0, 8'h0, 8'h1, 8'h0};
  logic [7:0] seq_br [6] = '{8'h0, 8'h0, 8'h0, 8'h1, 8'h0, 8'h0};
  logic [7:0] seq_c  [7] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h80};
  logic [7:0] seq_cv [7] = '{8'h1, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h1};
  logic [7:0] seq_e  [5] = '{8'h1, 8'h1, 8'h0, 8'h0, 8'h0};

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) cyc(0, 0, 0, 0);
    chk("rst_out_a", out_a, 8'h00);
    chk("rst_rdy_a", rdy_a, 8'h0);
    chk("rst_ov_b",  ov_b,  8'h0);
    rst_n = 1'b1;
    cyc(0, 0, 1, 0);
    chk("idle_rdy_a", rdy_a, 8'h1);
    chk("idle_rdy_b", rdy_b, 8'h1);

    // level decode sweep, one accept per cycle
    for (int i = 0; i < 8; i++) begin
      cyc(1, 3'(i), 1, 0);
      chk("lvl_out", out_a, seq_a[i]);
      chk("lvl_ov",  ov_a,  8'h1);
      chk("lvl_rdy", rdy_a, 8'h1);
    end

    // level hold with changing, unaccepted input
    cyc(1, 5, 1, 0);
    chk("hold_first", out_a, 8'h20);
    for (int j = 0; j < 10; j++) begin
      cyc(0, 3'(j), 1, 0);
      chk("hold_out", out_a, 8'h20);
      chk("hold_ov",  ov_a,  8'h0);
    end

    // pulse width and throughput with valid held high
    for (int j = 0; j < 6; j++) begin
      cyc(1, 2, 1, 0);
      chk("pls_out", out_b, seq_b[j]);
      chk("pls_ov",  ov_b,  seq_bv[j]);
      chk("pls_rdy", rdy_b, seq_br[j]);
    end

    // clr in second pulse cycle, then clr together with valid
    repeat (4) cyc(0, 0, 1, 0);
    cyc(1, 1, 1, 0);
    chk("clr_acc", out_b, 8'h2);
    cyc(0, 0, 1, 0);
    chk("clr_pls2", out_b, 8'h2);
    cyc(0, 0, 1, 1);
    chk("clr_out", out_b, 8'h0);
    cyc(1, 3, 1, 1);
    chk("clr_noacc_out", out_b, 8'h0);
    chk("clr_noacc_ov",  ov_b,  8'h0);
    chk("clr_noacc_a",   ov_a,  8'h0);
    cyc(0, 0, 1, 0);
    chk("clr_rdy_after", rdy_b, 8'h1);

    // asynchronous reset mid-pulse
    repeat (8) cyc(0, 0, 1, 0);
    cyc(1, 7, 1, 0);
    chk("ar_acc", out_c, 8'h80);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_out_c", out_c, 8'h00);
    chk("ar_ov_c",  ov_c,  8'h0);
    chk("ar_rdy_c", rdy_c, 8'h0);
    chk("ar_out_b", out_b, 8'h0);
    repeat (2) cyc(1, 7, 1, 0);
    chk("ar_held", out_c, 8'h00);
    rst_n = 1'b1;
    for (int j = 0; j < 7; j++) begin
      cyc(1, 7, 1, 0);
      chk("ar_pls_out", out_c, seq_c[j]);
      chk("ar_pls_ov",  ov_c,  seq_cv[j]);
    end

    // en low during a pulse: pulse finishes, no new accept
    repeat (8) cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 0);
    chk("en_acc", out_b, 8'h1);
    for (int j = 0; j < 5; j++) begin
      cyc(1, 1, 0, 0);
      chk("en_out", out_b, seq_e[j]);
      chk("en_rdy", rdy_b, 8'h0);
      chk("en_ov",  ov_b,  8'h0);
    end
    cyc(0, 0, 1, 0);
    chk("en_rdy_back", rdy_b, 8'h1);

    // randomized traffic with rare clr and reset pulses
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      cyc($urandom_range(0, 3) != 0, 3'($urandom),
          $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);
    end

    rst_n = 1'b1;
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
